ecc_block_sequencer: RTL and testbench
======================================

# ecc_block_sequencer

Multi-cycle sequencer for bulk Hamming(16,11) encode or decode of a block of 16-bit words in data memory. It sits between data memory and the combinational ALU. It reads byte pairs from memory, drives the ALU operands and the ECC opcodes (MSB_ECC/LSB_ECC for encode, MSB_ECC_INV/LSB_ECC_INV for decode), and writes the ALU result bytes back to a destination region. In decode mode it also counts the words that the ALU corrected.

## Interface
Parameters:
- W, 8: data/ALU byte width
- AW, 8: data memory address width
- CW, 6: width of the pair count

Ports:
- Clk  in  1  system clock; all state updates on its rising edge
- Reset_n  in  1  reset, asynchronous, active-low
- Start  in  1  request to begin a block operation; sampled only in IDLE
- Mode  in  1  0 = encode, 1 = decode; latched on accepted Start
- SrcBase  in  AW  source base address; latched on accepted Start
- DstBase  in  AW  destination base address; latched on accepted Start
- Count  in  CW  number of 16-bit words (byte pairs); latched on accepted Start
- Busy  out  1  high from the cycle after accepted Start through the DONE cycle
- Done  out  1  single-cycle completion pulse
- ErrCount  out  8  decode-mode corrected-word count; saturating
- DataAddr  out  AW  memory address (combinational-read memory)
- DataIn  in  W  memory read data for DataAddr, same cycle
- DataOut  out  W  memory write data; equals AluOut combinationally
- WriteEn  out  1  memory write strobe; write occurs on the Clk edge ending the cycle
- AluA  out  W  ALU InputA, registered low byte
- AluB  out  W  ALU InputB, registered high byte
- AluCtrl  out  4  ALU opcode
- AluOut  in  W  ALU result

## Operation
- Memory layout: word i occupies Base+2i (low byte) and Base+2i+1 (high byte). Address arithmetic is modulo 2^AW and wraps silently.
- Encode message format: the 11 message bits are {hi[2:0], lo[7:0]}. Decode operates on full 16-bit codewords and writes the corrected codeword bytes.
- FSM states: IDLE, RD_LO, RD_HI, WR_HI, WR_LO, DONE.
- IDLE: when Start=1, latch Mode/SrcBase/DstBase/Count, clear index i and ErrCount. Go to DONE if Count=0, otherwise go to RD_LO. Start is ignored in every other state.
- RD_LO: DataAddr=SrcBase+2i; lo register <= DataIn.
- RD_HI: DataAddr=SrcBase+2i+1; hi register <= DataIn.
- WR_HI: AluCtrl = 4'b0100 (encode) or 4'b0110 (decode); DataAddr=DstBase+2i+1; WriteEn=1.
- WR_LO: AluCtrl = 4'b0101 (encode) or 4'b0111 (decode); DataAddr=DstBase+2i; WriteEn=1.
- After WR_LO: if i=Count-1, go to DONE; otherwise i <= i+1 and go to RD_LO.
- AluA is always the lo register and AluB is always the hi register.
- Error counting (decode only): a word counts as corrected if AluOut≠hi during WR_HI or AluOut≠lo during WR_LO. ErrCount increments at most once per word and saturates at 255. Encode mode never changes ErrCount.
- DONE: Done=1 for exactly one cycle, then return to IDLE. ErrCount holds its value until the next accepted Start.
- Overlapping source and destination regions are allowed. Each word is read completely before either of its bytes is written.

## Timing
- Reset (asynchronous assert, any state): state=IDLE, Busy=0, Done=0, WriteEn=0, ErrCount=0, DataAddr=0, AluA=0, AluB=0, AluCtrl=4'b0000, i=0, lo=0, hi=0. An in-flight block is abandoned, and no write strobe is issued in the cycle of or after reset.
- DataAddr, WriteEn and AluCtrl are decoded from registered state/index only. They never depend on Start, DataIn or AluOut.
- Throughput: 4 cycles per word.
- Latency: Done is high in cycle 4·Count+1 after the Start edge. With Count=0, Done is high in cycle 1.
- WriteEn is high only in WR_HI and WR_LO. It is low in IDLE, RD_* and DONE.
- A Start arriving while Done=1 is ignored; it is accepted only once the FSM is back in IDLE.
- Count=2^CW−1 must complete without index overflow, because i is CW bits wide.

## Test plan
- Encode, Count=1, SrcBase=0x00: mem[0]=0xFF, mem[1]=0x07, DstBase=0x20 -> mem[0x20]=0xFF, mem[0x21]=0xFF; Done in cycle 5; ErrCount=0.
- Encode, Count=1, source 0x01/0x00 -> destination low byte 0x0F, high byte 0x00; write order is high byte then low byte.
- Decode, Count=2: words {0xFF,0xFF} and {0xFE,0xFF} (low, high) -> both written back as 0xFF/0xFF; ErrCount=1; Done in cycle 9.
- Count=0 with Start -> no WriteEn pulses; Done in cycle 1; Busy high for one cycle only.
- Reset_n pulsed low during WR_HI of word 3 of 5 -> outputs take reset values immediately; no further writes; a subsequent Start runs the full block correctly.
- Start held high through a whole block, with DstBase wrapping (DstBase=0xFE, Count=2) -> second word is written to 0x00/0x01; the second Start is taken only after IDLE is re-entered.

Source files
------------

// File: rtl/ecc_block_sequencer.sv
// Sequences a block-wide Hamming(16,11) encode/decode through an external combinational ALU:
// read low/high bytes, write the high result then the low result, and count corrected words when decoding.
module ecc_block_sequencer #(
    parameter int W  = 8,
    parameter int AW = 8,
    parameter int CW = 6
) (
    input  logic          Clk,
    input  logic          Reset_n,
    input  logic          Start,
    input  logic          Mode,
    input  logic [AW-1:0] SrcBase,
    input  logic [AW-1:0] DstBase,
    input  logic [CW-1:0] Count,
    output logic          Busy,
    output logic          Done,
    output logic [7:0]    ErrCount,
    output logic [AW-1:0] DataAddr,
    input  logic [W-1:0]  DataIn,
    output logic [W-1:0]  DataOut,
    output logic          WriteEn,
    output logic [W-1:0]  AluA,
    output logic [W-1:0]  AluB,
    output logic [3:0]    AluCtrl,
    input  logic [W-1:0]  AluOut
);

    typedef enum logic [2:0] {
        IDLE,
        RD_LO,
        RD_HI,
        WR_HI,
        WR_LO,
        DONE
    } state_t;

    state_t        state, state_d;
    logic          mode_q;
    logic [AW-1:0] src_q, dst_q;
    logic [CW-1:0] cnt_q, idx;
    logic [W-1:0]  lo, hi;
    logic [7:0]    err_cnt;
    logic          hi_err;
    logic [AW-1:0] offset;
    logic          last_word;

    // Byte offset of word idx; address sums wrap modulo 2^AW.
    assign offset    = AW'({idx, 1'b0});
    assign last_word = (idx == cnt_q - CW'(1));

    assign DataOut  = AluOut;
    assign AluA     = lo;
    assign AluB     = hi;
    assign ErrCount = err_cnt;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d  = state;
        Busy     = (state != IDLE);
        Done     = 1'b0;
        WriteEn  = 1'b0;
        AluCtrl  = 4'b0000;
        DataAddr = '0;
        case (state)
            IDLE: begin
                if (Start) begin
                    state_d = (Count == '0) ? DONE : RD_LO;
                end
            end
            RD_LO: begin
                DataAddr = src_q + offset;
                state_d  = RD_HI;
            end
            RD_HI: begin
                DataAddr = src_q + offset + AW'(1);
                state_d  = WR_HI;
            end
            WR_HI: begin
                WriteEn  = 1'b1;
                AluCtrl  = mode_q ? 4'b0110 : 4'b0100;
                DataAddr = dst_q + offset + AW'(1);
                state_d  = WR_LO;
            end
            WR_LO: begin
                WriteEn  = 1'b1;
                AluCtrl  = mode_q ? 4'b0111 : 4'b0101;
                DataAddr = dst_q + offset;
                state_d  = last_word ? DONE : RD_LO;
            end
            DONE: begin
                Done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            mode_q  <= 1'b0;
            src_q   <= '0;
            dst_q   <= '0;
            cnt_q   <= '0;
            idx     <= '0;
            lo      <= '0;
            hi      <= '0;
            err_cnt <= '0;
            hi_err  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (Start) begin
                        mode_q  <= Mode;
                        src_q   <= SrcBase;
                        dst_q   <= DstBase;
                        cnt_q   <= Count;
                        idx     <= '0;
                        err_cnt <= '0;
                        hi_err  <= 1'b0;
                    end
                end
                RD_LO: lo <= DataIn;
                RD_HI: hi <= DataIn;
                WR_HI: hi_err <= mode_q && (AluOut != hi);
                WR_LO: begin
                    // A word is counted once even if both of its bytes were corrected.
                    if (mode_q && (hi_err || (AluOut != lo)) && (err_cnt != 8'hFF)) begin
                        err_cnt <= err_cnt + 8'd1;
                    end
                    hi_err <= 1'b0;
                    if (!last_word) begin
                        idx <= idx + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ecc_block_sequencer.sv
// Directed bench for ecc_block_sequencer with a byte memory and a Hamming(16,11) ALU model
// (11 message bits at non-power-of-two positions 3..15, parity at 1/2/4/8, overall parity at bit 0).
module tb_ecc_block_sequencer;

    logic       Clk = 1'b0;
    logic       Reset_n = 1'b1;
    logic       Start = 1'b0;
    logic       Mode = 1'b0;
    logic [7:0] SrcBase = '0;
    logic [7:0] DstBase = '0;
    logic [5:0] Count = '0;
    logic       Busy, Done, WriteEn;
    logic [7:0] ErrCount, DataAddr, DataIn, DataOut, AluA, AluB, AluOut;
    logic [3:0] AluCtrl;

    int errors = 0;
    int checks = 0;

    logic [7:0] mem [256];
    logic [7:0] wr_addr [$];
    logic [7:0] wr_data [$];
    logic [3:0] wr_ctrl [$];

    ecc_block_sequencer #(.W(8), .AW(8), .CW(6)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .Mode(Mode),
        .SrcBase(SrcBase), .DstBase(DstBase), .Count(Count),
        .Busy(Busy), .Done(Done), .ErrCount(ErrCount),
        .DataAddr(DataAddr), .DataIn(DataIn), .DataOut(DataOut), .WriteEn(WriteEn),
        .AluA(AluA), .AluB(AluB), .AluCtrl(AluCtrl), .AluOut(AluOut)
    );

    always #5 Clk = ~Clk;

    function automatic logic [7:0] alu(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [15:0] cw;
        logic [10:0] msg;
        logic [3:0]  syn;
        logic        par;
        int unsigned k;
        cw  = '0;
        msg = {b[2:0], a};
        if (op == 4'b0100 || op == 4'b0101) begin
            k = 0;
            for (int p = 1; p < 16; p++) begin
                if ((p & (p - 1)) != 0) begin
                    cw[p] = msg[k];
                    k++;
                end
            end
            for (int j = 0; j < 4; j++) begin
                par = 1'b0;
                for (int p = 1; p < 16; p++) begin
                    if (p != (1 << j) && ((p >> j) & 1) == 1) par = par ^ cw[p];
                end
                cw[1 << j] = par;
            end
            cw[0] = ^cw[15:1];
        end else if (op == 4'b0110 || op == 4'b0111) begin
            cw  = {b, a};
            syn = '0;
            for (int p = 1; p < 16; p++) begin
                if (cw[p]) syn = syn ^ 4'(p);
            end
            if (^cw) cw[syn] = ~cw[syn];
        end
        return op[0] ? cw[7:0] : cw[15:8];
    endfunction

    always_comb AluOut = alu(AluCtrl, AluA, AluB);
    assign DataIn = mem[DataAddr];

    always @(posedge Clk) begin
        if (WriteEn) begin
            mem[DataAddr] <= DataOut;
            wr_addr.push_back(DataAddr);
            wr_data.push_back(DataOut);
            wr_ctrl.push_back(AluCtrl);
        end
    end

    task automatic start_block(input logic m, input logic [7:0] s, input logic [7:0] d,
                               input logic [5:0] n, input bit hold);
        @(negedge Clk);
        Mode = m; SrcBase = s; DstBase = d; Count = n; Start = 1'b1;
        @(posedge Clk);
        #1;
        if (!hold) Start = 1'b0;
    endtask

    // Called in cycle 1 of a block; returns the Done cycle (0 on timeout) and Busy cycles, then steps into IDLE.
    task automatic wait_done(input int limit, output int dcyc, output int bcyc);
        dcyc = 0;
        bcyc = 0;
        for (int c = 1; c <= limit; c++) begin
            if (Busy) bcyc++;
            if (Done) begin
                dcyc = c;
                break;
            end
            @(posedge Clk);
            #1;
        end
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        #3 Reset_n = 1'b0;
        #1;
        checks++; if (Busy !== 1'b0)     begin errors++; $display("FAIL reset_busy: got %0h want 0", Busy); end
        checks++; if (Done !== 1'b0)     begin errors++; $display("FAIL reset_done: got %0h want 0", Done); end
        checks++; if (WriteEn !== 1'b0)  begin errors++; $display("FAIL reset_we: got %0h want 0", WriteEn); end
        checks++; if (ErrCount !== 8'h0) begin errors++; $display("FAIL reset_errcount: got %0h want 0", ErrCount); end
        checks++; if (DataAddr !== 8'h0) begin errors++; $display("FAIL reset_addr: got %0h want 0", DataAddr); end
        checks++; if (AluA !== 8'h0)     begin errors++; $display("FAIL reset_alua: got %0h want 0", AluA); end
        checks++; if (AluB !== 8'h0)     begin errors++; $display("FAIL reset_alub: got %0h want 0", AluB); end
        checks++; if (AluCtrl !== 4'h0)  begin errors++; $display("FAIL reset_aluctrl: got %0h want 0", AluCtrl); end
        repeat (2) @(posedge Clk);
        @(negedge Clk) Reset_n = 1'b1;
    endtask

    task automatic test_encode_ones();
        int dc, bc, base;
        mem[8'h00] = 8'hFF; mem[8'h01] = 8'h07;
        base = wr_addr.size();
        start_block(1'b0, 8'h00, 8'h20, 6'd1, 1'b0);
        wait_done(20, dc, bc);
        checks++; if (dc != 5)  begin errors++; $display("FAIL enc1_done_cycle: got %0d want 5", dc); end
        checks++; if (bc != 5)  begin errors++; $display("FAIL enc1_busy_cycles: got %0d want 5", bc); end
        checks++; if (mem[8'h20] !== 8'hFF) begin errors++; $display("FAIL enc1_lo: got %0h want ff", mem[8'h20]); end
        checks++; if (mem[8'h21] !== 8'hFF) begin errors++; $display("FAIL enc1_hi: got %0h want ff", mem[8'h21]); end
        checks++; if (ErrCount !== 8'h0) begin errors++; $display("FAIL enc1_errcount: got %0h want 0", ErrCount); end
        checks++; if (wr_addr.size() - base != 2) begin errors++; $display("FAIL enc1_writes: got %0d want 2", wr_addr.size() - base); end
    endtask

    task automatic test_encode_order();
        int dc, bc, base;
        mem[8'h02] = 8'h01; mem[8'h03] = 8'h00;
        base = wr_addr.size();
        start_block(1'b0, 8'h02, 8'h30, 6'd1, 1'b0);
        wait_done(20, dc, bc);
        checks++; if (wr_addr.size() - base != 2) begin
            errors++; $display("FAIL order_writes: got %0d want 2", wr_addr.size() - base);
        end else begin
            checks++; if (wr_addr[base] !== 8'h31)   begin errors++; $display("FAIL order_addr0: got %0h want 31", wr_addr[base]); end
            checks++; if (wr_data[base] !== 8'h00)   begin errors++; $display("FAIL order_data0: got %0h want 00", wr_data[base]); end
            checks++; if (wr_ctrl[base] !== 4'b0100) begin errors++; $display("FAIL order_ctrl0: got %0h want 4", wr_ctrl[base]); end
            checks++; if (wr_addr[base+1] !== 8'h30) begin errors++; $display("FAIL order_addr1: got %0h want 30", wr_addr[base+1]); end
            checks++; if (wr_data[base+1] !== 8'h0F) begin errors++; $display("FAIL order_data1: got %0h want 0f", wr_data[base+1]); end
            checks++; if (wr_ctrl[base+1] !== 4'b0101) begin errors++; $display("FAIL order_ctrl1: got %0h want 5", wr_ctrl[base+1]); end
        end
    endtask

    task automatic test_decode();
        int dc, bc, base;
        mem[8'h40] = 8'hFF; mem[8'h41] = 8'hFF; mem[8'h42] = 8'hFE; mem[8'h43] = 8'hFF;
        base = wr_addr.size();
        start_block(1'b1, 8'h40, 8'h50, 6'd2, 1'b0);
        wait_done(40, dc, bc);
        checks++; if (dc != 9) begin errors++; $display("FAIL dec_done_cycle: got %0d want 9", dc); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (mem[8'h50 + i] !== 8'hFF) begin errors++; $display("FAIL dec_byte%0d: got %0h want ff", i, mem[8'h50 + i]); end
        end
        checks++; if (ErrCount !== 8'd1) begin errors++; $display("FAIL dec_errcount: got %0d want 1", ErrCount); end
        checks++; if (wr_ctrl[base] !== 4'b0110)   begin errors++; $display("FAIL dec_ctrl_hi: got %0h want 6", wr_ctrl[base]); end
        checks++; if (wr_ctrl[base+1] !== 4'b0111) begin errors++; $display("FAIL dec_ctrl_lo: got %0h want 7", wr_ctrl[base+1]); end
        // High-byte error in the first word; ErrCount must restart from zero for this block.
        mem[8'h44] = 8'hFF; mem[8'h45] = 8'h7F; mem[8'h46] = 8'h00; mem[8'h47] = 8'h00;
        start_block(1'b1, 8'h44, 8'h58, 6'd2, 1'b0);
        wait_done(40, dc, bc);
        checks++; if (mem[8'h59] !== 8'hFF) begin errors++; $display("FAIL dec2_hi0: got %0h want ff", mem[8'h59]); end
        checks++; if (mem[8'h5A] !== 8'h00) begin errors++; $display("FAIL dec2_lo1: got %0h want 00", mem[8'h5A]); end
        checks++; if (ErrCount !== 8'd1) begin errors++; $display("FAIL dec2_errcount: got %0d want 1", ErrCount); end
    endtask

    task automatic test_count_zero();
        int dc, bc, base;
        base = wr_addr.size();
        start_block(1'b0, 8'h00, 8'h90, 6'd0, 1'b0);
        wait_done(10, dc, bc);
        checks++; if (dc != 1) begin errors++; $display("FAIL zero_done_cycle: got %0d want 1", dc); end
        checks++; if (bc != 1) begin errors++; $display("FAIL zero_busy_cycles: got %0d want 1", bc); end
        checks++; if (wr_addr.size() != base) begin errors++; $display("FAIL zero_writes: got %0d want 0", wr_addr.size() - base); end
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL zero_busy_after: got %0h want 0", Busy); end
    endtask

    task automatic test_reset_midblock();
        int dc, bc, base;
        logic [7:0] src [10];
        logic [7:0] exp [10];
        src = '{8'h00, 8'h00, 8'h01, 8'h00, 8'h02, 8'h00, 8'hFF, 8'h07, 8'h03, 8'h00};
        exp = '{8'h00, 8'h00, 8'h0F, 8'h00, 8'h33, 8'h00, 8'hFF, 8'hFF, 8'h3C, 8'h00};
        for (int i = 0; i < 10; i++) begin
            mem[8'h60 + i] = src[i];
            mem[8'h80 + i] = 8'hAA;
        end
        base = wr_addr.size();
        start_block(1'b0, 8'h60, 8'h80, 6'd5, 1'b0);
        repeat (10) @(posedge Clk);
        #1;
        checks++; if (WriteEn !== 1'b1)  begin errors++; $display("FAIL mid_we_before: got %0h want 1", WriteEn); end
        checks++; if (DataAddr !== 8'h85) begin errors++; $display("FAIL mid_addr_before: got %0h want 85", DataAddr); end
        #1 Reset_n = 1'b0;
        #1;
        checks++; if (WriteEn !== 1'b0)  begin errors++; $display("FAIL mid_we: got %0h want 0", WriteEn); end
        checks++; if (Busy !== 1'b0)     begin errors++; $display("FAIL mid_busy: got %0h want 0", Busy); end
        checks++; if (DataAddr !== 8'h0) begin errors++; $display("FAIL mid_addr: got %0h want 0", DataAddr); end
        checks++; if (AluA !== 8'h0)     begin errors++; $display("FAIL mid_alua: got %0h want 0", AluA); end
        checks++; if (AluB !== 8'h0)     begin errors++; $display("FAIL mid_alub: got %0h want 0", AluB); end
        checks++; if (AluCtrl !== 4'h0)  begin errors++; $display("FAIL mid_aluctrl: got %0h want 0", AluCtrl); end
        repeat (2) @(posedge Clk);
        @(negedge Clk) Reset_n = 1'b1;
        repeat (2) @(posedge Clk);
        #1;
        checks++; if (wr_addr.size() - base != 4) begin errors++; $display("FAIL mid_writes: got %0d want 4", wr_addr.size() - base); end
        checks++; if (mem[8'h85] !== 8'hAA) begin errors++; $display("FAIL mid_untouched: got %0h want aa", mem[8'h85]); end
        base = wr_addr.size();
        start_block(1'b0, 8'h60, 8'h80, 6'd5, 1'b0);
        wait_done(60, dc, bc);
        checks++; if (dc != 21) begin errors++; $display("FAIL rerun_done_cycle: got %0d want 21", dc); end
        checks++; if (wr_addr.size() - base != 10) begin errors++; $display("FAIL rerun_writes: got %0d want 10", wr_addr.size() - base); end
        for (int i = 0; i < 10; i++) begin
            checks++; if (mem[8'h80 + i] !== exp[i]) begin errors++; $display("FAIL rerun_byte%0d: got %0h want %0h", i, mem[8'h80 + i], exp[i]); end
        end
    endtask

    task automatic test_back_to_back();
        int dc, bc, base;
        logic [7:0] exp_addr [4];
        exp_addr = '{8'hFF, 8'hFE, 8'h01, 8'h00};
        mem[8'h70] = 8'h01; mem[8'h71] = 8'h00; mem[8'h72] = 8'hFF; mem[8'h73] = 8'h07;
        base = wr_addr.size();
        start_block(1'b0, 8'h70, 8'hFE, 6'd2, 1'b1);
        wait_done(40, dc, bc);
        checks++; if (dc != 9) begin errors++; $display("FAIL wrap_done_cycle: got %0d want 9", dc); end
        checks++; if (wr_addr.size() - base < 4) begin
            errors++; $display("FAIL wrap_writes: got %0d want 4", wr_addr.size() - base);
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++; if (wr_addr[base+i] !== exp_addr[i]) begin errors++; $display("FAIL wrap_addr%0d: got %0h want %0h", i, wr_addr[base+i], exp_addr[i]); end
            end
        end
        checks++; if (mem[8'hFE] !== 8'h0F) begin errors++; $display("FAIL wrap_fe: got %0h want 0f", mem[8'hFE]); end
        checks++; if (mem[8'hFF] !== 8'h00) begin errors++; $display("FAIL wrap_ff: got %0h want 00", mem[8'hFF]); end
        checks++; if (mem[8'h00] !== 8'hFF) begin errors++; $display("FAIL wrap_00: got %0h want ff", mem[8'h00]); end
        checks++; if (mem[8'h01] !== 8'hFF) begin errors++; $display("FAIL wrap_01: got %0h want ff", mem[8'h01]); end
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL held_idle_busy: got %0h want 0", Busy); end
        @(posedge Clk);
        #1;
        checks++; if (Busy !== 1'b1) begin errors++; $display("FAIL held_restart_busy: got %0h want 1", Busy); end
        checks++; if (DataAddr !== 8'h70) begin errors++; $display("FAIL held_restart_addr: got %0h want 70", DataAddr); end
        Start = 1'b0;
        wait_done(40, dc, bc);
        checks++; if (dc != 9) begin errors++; $display("FAIL held_second_done: got %0d want 9", dc); end
    endtask

    task automatic test_max_count();
        int dc, bc, base;
        base = wr_addr.size();
        start_block(1'b0, 8'h00, 8'h80, 6'd63, 1'b0);
        wait_done(300, dc, bc);
        checks++; if (dc != 253) begin errors++; $display("FAIL max_done_cycle: got %0d want 253", dc); end
        checks++; if (bc != 253) begin errors++; $display("FAIL max_busy_cycles: got %0d want 253", bc); end
        checks++; if (wr_addr.size() - base != 126) begin
            errors++; $display("FAIL max_writes: got %0d want 126", wr_addr.size() - base);
        end else begin
            checks++; if (wr_addr[base+125] !== 8'hFC) begin errors++; $display("FAIL max_last_addr: got %0h want fc", wr_addr[base+125]); end
            checks++; if (wr_addr[base+124] !== 8'hFD) begin errors++; $display("FAIL max_prev_addr: got %0h want fd", wr_addr[base+124]); end
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        test_reset();
        test_encode_ones();
        test_encode_order();
        test_decode();
        test_count_zero();
        test_reset_midblock();
        test_back_to_back();
        test_max_count();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
